store_buffer: RTL and testbench
===============================

Name: store_buffer

Overview:
- Posted-write buffer directly upstream of the data memory (MEM). Pipeline stores are captured into a small FIFO and drained to MEM in cycles when the shared memory port is not needed by a load.
- Loads check the buffer and forward the youngest matching pending store; otherwise they return MEM's read data.
- Drives MEM's clk-synchronous write and combinational read through MEM's single Address port.

Parameters:
- DEPTH, 4, number of buffer entries; must be a power of 2, at least 2.
- DATA_WIDTH, 8, store/load data width (matches MEM).
- DATA_DIR_WIDTH, 8, address width (matches MEM).
- MATCH_WIDTH, 2, low address bits compared for forwarding; equals the address bits MEM decodes.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- MemWrite  in  1  pipeline store request this cycle
- MemRead  in  1  pipeline load request this cycle
- Address  in  DATA_DIR_WIDTH  pipeline load/store address
- WriteData  in  DATA_WIDTH  pipeline store data
- drain_req  in  1  request to empty the buffer (sync before halt/IO)
- ReadData  out  DATA_WIDTH  load result to pipeline
- stall  out  1  pipeline must hold the current op and retry next cycle
- empty  out  1  buffer holds no entries
- mem_write  out  1  to MEM MemWrite
- mem_read  out  1  to MEM MemRead
- mem_addr  out  DATA_DIR_WIDTH  to MEM Address
- mem_wdata  out  DATA_WIDTH  to MEM WriteData
- mem_rdata  in  DATA_WIDTH  from MEM ReadData

Behaviour:
- Storage: DEPTH entries of {addr, data}; head/tail pointers of log2(DEPTH) bits wrap modulo DEPTH; count of log2(DEPTH)+1 bits; full = (count==DEPTH), empty = (count==0).
- Reset (async, rst=1): pointers and count are 0; pending stores are discarded, including on reset mid-operation. Entry contents are don't-care. Outputs during reset: empty=1, stall=0, mem_write=0, mem_read=0.
- Memory port arbitration (combinational):
  - MemRead=1: mem_read=1, mem_addr=Address, mem_write=0 (no drain).
  - Otherwise, if !empty: mem_write=1, mem_addr/mem_wdata = head entry, mem_read=0; head advances and count decrements at the clock edge.
  - Otherwise: all memory strobes are 0. mem_addr=Address, mem_wdata=0.
- Enqueue on a clock edge when MemWrite=1 and the store is accepted:
  - Accepted when !full, or when full and a drain occurs the same cycle (MemRead=0).
  - Entry is written at tail; tail advances.
  - Simultaneous enqueue and drain leaves count unchanged.
- Load result (combinational, zero added latency):
  - Compare Address[MATCH_WIDTH-1:0] against every valid entry's addr[MATCH_WIDTH-1:0].
  - Any hit: ReadData = data of the youngest hit (closest to tail).
  - No hit: ReadData = mem_rdata.
  - MemRead=0: ReadData=0.
  - A store enqueued in the same cycle is not visible to that cycle's load.
- MemRead=1 and MemWrite=1 together:
  - Load is serviced as above.
  - If !full, the store is also enqueued.
  - If full, the store is not accepted and stall=1.
- stall = (MemRead & MemWrite & full) | (drain_req & !empty).
  - While stall=1, the buffer still drains whenever MemRead=0.
  - While stall=1, the store is not enqueued, and the pipeline re-presents it.
- Drain ordering is strictly FIFO. Two stores to the same address reach MEM in program order.
- empty is combinational from count.

Test Plan:
- Reset then idle: rst pulse -> empty=1, stall=0, mem_write=0, mem_read=0. No MEM writes occur over 10 idle cycles.
- Store then drain: store A=0x01 D=0x55 with MemRead=0 throughout -> entry enqueued at edge 1. Next cycle mem_write=1, mem_addr=0x01, mem_wdata=0x55; empty=1 after edge 2. A later load of 0x01 returns 0x55 from MEM.
- Forwarding youngest: back-to-back stores 0x02/0x11 then 0x02/0x22, followed immediately by loads every cycle (no drain) -> ReadData=0x22, mem_write=0 during the loads. Load of 0x03 returns mem_rdata.
- Alias match: pending store 0x06/0x77, load of 0x02 (low 2 bits equal) -> ReadData=0x77.
- Full with load+store: fill 4 entries under continuous loads, then assert MemRead=1 and MemWrite=1 -> stall=1, count stays 4, load still returns correct data. Drop MemRead -> store accepted while head drains, count stays 4.
- drain_req with 3 entries and no loads -> stall=1 for exactly 3 cycles, the 3 writes reach MEM in FIFO order, then empty=1 and stall=0. Assert rst mid-drain -> empty=1 immediately and no further mem_write.

Source files
------------

// File: rtl/store_buffer.sv
// Posted-write store buffer sitting in front of the data memory.
// Stores are queued in a small FIFO and drained to MEM whenever the shared
// memory port is not busy with a load. Loads forward the youngest pending
// store whose low address bits match; otherwise they see MEM's read data.
module store_buffer #(
    parameter int DEPTH          = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int DATA_DIR_WIDTH = 8,
    parameter int MATCH_WIDTH    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      MemWrite,
    input  logic                      MemRead,
    input  logic [DATA_DIR_WIDTH-1:0] Address,
    input  logic [DATA_WIDTH-1:0]     WriteData,
    input  logic                      drain_req,
    output logic [DATA_WIDTH-1:0]     ReadData,
    output logic                      stall,
    output logic                      empty,
    output logic                      mem_write,
    output logic                      mem_read,
    output logic [DATA_DIR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    input  logic [DATA_WIDTH-1:0]     mem_rdata
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [DATA_DIR_WIDTH-1:0] entryAddr [DEPTH];
    logic [DATA_WIDTH-1:0]     entryData [DEPTH];

    logic [PTR_W-1:0] headPtr, headNext;
    logic [PTR_W-1:0] tailPtr, tailNext;
    logic [CNT_W-1:0] count, countNext;

    logic full;
    logic drain;
    logic accept;
    logic hit;
    logic [DATA_WIDTH-1:0] fwdData;

    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);

    // The port belongs to a load when one is present; otherwise drain the head.
    assign drain = !MemRead && !empty;

    assign stall = (MemRead && MemWrite && full) || (drain_req && !empty);

    // A full buffer can still take a store if the head leaves in the same cycle.
    assign accept = MemWrite && !stall && (!full || drain);

    // Memory port arbitration; mem_read is held off while reset is asserted.
    always_comb begin
        mem_read  = MemRead && !rst;
        mem_write = drain;
        mem_addr  = Address;
        mem_wdata = '0;
        if (drain) begin
            mem_addr  = entryAddr[headPtr];
            mem_wdata = entryData[headPtr];
        end
    end

    // Forwarding search, oldest to youngest so the youngest hit wins.
    always_comb begin
        logic [PTR_W-1:0] idx;
        hit     = 1'b0;
        fwdData = '0;
        idx     = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = headPtr + PTR_W'(k);
            if ((CNT_W'(k) < count) &&
                (entryAddr[idx][MATCH_WIDTH-1:0] == Address[MATCH_WIDTH-1:0])) begin
                hit     = 1'b1;
                fwdData = entryData[idx];
            end
        end
    end

    // Load result: forwarded data, else memory data, else zero when idle.
    always_comb begin
        ReadData = '0;
        if (MemRead) begin
            ReadData = hit ? fwdData : mem_rdata;
        end
    end

    // Next-state for pointers and occupancy.
    always_comb begin
        headNext  = headPtr;
        tailNext  = tailPtr;
        countNext = count;
        if (drain) begin
            headNext = headPtr + PTR_W'(1);
        end
        if (accept) begin
            tailNext = tailPtr + PTR_W'(1);
        end
        case ({accept, drain})
            2'b10:   countNext = count + CNT_W'(1);
            2'b01:   countNext = count - CNT_W'(1);
            default: countNext = count;
        endcase
    end

    // Pointer and count registers; reset discards every pending store.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            headPtr <= '0;
            tailPtr <= '0;
            count   <= '0;
        end else begin
            headPtr <= headNext;
            tailPtr <= tailNext;
            count   <= countNext;
        end
    end

    // Entry storage; contents are meaningless unless covered by count.
    always_ff @(posedge clk) begin
        if (accept) begin
            entryAddr[tailPtr] <= Address;
            entryData[tailPtr] <= WriteData;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Randomized self-checking bench for store_buffer. A queue-based model of the
// buffer plus a reference memory predicts every output each cycle; a separate
// memory driven only by the DUT's strobes supplies mem_rdata.
module tb_store_buffer;

    logic       clk = 1'b0;
    logic       rst;
    logic       MemWrite, MemRead, drain_req;
    logic [7:0] Address, WriteData;
    logic [7:0] ReadData;
    logic       stall, empty;
    logic       mem_write, mem_read;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    store_buffer #(
        .DEPTH(4), .DATA_WIDTH(8), .DATA_DIR_WIDTH(8), .MATCH_WIDTH(2)
    ) dut (
        .clk(clk), .rst(rst),
        .MemWrite(MemWrite), .MemRead(MemRead), .Address(Address),
        .WriteData(WriteData), .drain_req(drain_req),
        .ReadData(ReadData), .stall(stall), .empty(empty),
        .mem_write(mem_write), .mem_read(mem_read), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Memory written only by the DUT; decodes the low two address bits.
    logic [7:0] dutMem [4];
    logic       memClear;
    always @(posedge clk) begin
        if (memClear) begin
            for (int i = 0; i < 4; i++) dutMem[i] <= 8'h00;
        end else if (mem_write) begin
            dutMem[mem_addr[1:0]] <= mem_wdata;
        end
    end
    assign mem_rdata = dutMem[mem_addr[1:0]];

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } entry_t;

    entry_t     q[$];
    logic [7:0] refMem [4];
    int         nChecks = 0;
    int         nFails  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive, check combinational outputs, advance the model.
    task automatic cycle(input bit mr, input bit mw, input logic [7:0] a,
                         input logic [7:0] d, input bit dr);
        bit         expEmpty, expFull, expStall, expDrain, expAccept;
        logic [7:0] expAddr, expWdata, expRead;
        @(negedge clk);
        MemRead = mr; MemWrite = mw; Address = a; WriteData = d; drain_req = dr;
        #1;
        expEmpty  = (q.size() == 0);
        expFull   = (q.size() == 4);
        expStall  = (mr && mw && expFull) || (dr && !expEmpty);
        expDrain  = !mr && !expEmpty;
        expAccept = mw && !expStall && (!expFull || expDrain);
        expAddr   = expDrain ? q[0].addr : a;
        expWdata  = expDrain ? q[0].data : 8'h00;
        expRead   = 8'h00;
        if (mr) begin
            expRead = refMem[a[1:0]];
            foreach (q[i]) if (q[i].addr[1:0] == a[1:0]) expRead = q[i].data;
        end
        check("empty", 32'(empty), 32'(expEmpty));
        check("stall", 32'(stall), 32'(expStall));
        check("mem_write", 32'(mem_write), 32'(expDrain));
        check("mem_read", 32'(mem_read), 32'(mr));
        check("mem_addr", 32'(mem_addr), 32'(expAddr));
        check("mem_wdata", 32'(mem_wdata), 32'(expWdata));
        check("ReadData", 32'(ReadData), 32'(expRead));
        if (expDrain) begin
            refMem[q[0].addr[1:0]] = q[0].data;
            void'(q.pop_front());
        end
        if (expAccept) q.push_back('{addr: a, data: d});
    endtask

    // Asynchronous reset asserted mid-cycle with every request active.
    task automatic midReset();
        @(negedge clk);
        MemRead = 1'b1; MemWrite = 1'b1; drain_req = 1'b1; Address = 8'h05; WriteData = 8'h99;
        #1;
        rst = 1'b1;
        #1;
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_mem_write", 32'(mem_write), 32'd0);
        check("rst_mem_read", 32'(mem_read), 32'd0);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        MemRead = 1'b0; MemWrite = 1'b0; drain_req = 1'b0;
    endtask

    initial begin
        rst = 1'b1; memClear = 1'b1;
        MemRead = 1'b0; MemWrite = 1'b0; drain_req = 1'b0;
        Address = 8'h00; WriteData = 8'h00;
        for (int i = 0; i < 4; i++) refMem[i] = 8'h00;
        @(posedge clk);
        #1 memClear = 1'b0;
        check("reset_empty", 32'(empty), 32'd1);
        check("reset_stall", 32'(stall), 32'd0);
        check("reset_mem_write", 32'(mem_write), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Idle: no memory writes.
        for (int i = 0; i < 10; i++) cycle(0, 0, 8'(i), 8'h00, 0);
        // Store, drain, then load it back from memory.
        cycle(0, 1, 8'h01, 8'h55, 0);
        cycle(0, 0, 8'h00, 8'h00, 0);
        cycle(1, 0, 8'h01, 8'h00, 0);
        check("load_after_drain", 32'(ReadData), 32'h55);
        // Youngest forwarding, same-cycle store invisible, miss goes to memory.
        cycle(0, 1, 8'h02, 8'h11, 0);
        cycle(1, 1, 8'h02, 8'h22, 0);
        cycle(1, 0, 8'h02, 8'h00, 0);
        check("fwd_youngest", 32'(ReadData), 32'h22);
        cycle(1, 0, 8'h03, 8'h00, 0);
        // Alias on low address bits.
        cycle(1, 1, 8'h06, 8'h77, 0);
        cycle(1, 0, 8'h02, 8'h00, 0);
        check("fwd_alias", 32'(ReadData), 32'h77);
        // Fill to full, then load+store stalls, then store alone is accepted.
        cycle(1, 1, 8'h10, 8'hA0, 0);
        cycle(1, 1, 8'h14, 8'hB0, 0);
        check("full_stall", 32'(stall), 32'd1);
        cycle(0, 1, 8'h14, 8'hB0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 0, 8'h00, 8'h00, 0);
        // drain_req with three entries.
        for (int i = 0; i < 3; i++) cycle(1, 1, 8'(8'h20 + i), 8'(8'hC0 + i), 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 8'h00, 8'h00, 1);
        // Reset in the middle of a drain.
        for (int i = 0; i < 3; i++) cycle(1, 1, 8'(8'h30 + i), 8'(8'hD0 + i), 0);
        cycle(0, 0, 8'h00, 8'h00, 1);
        midReset();
        for (int i = 0; i < 4; i++) cycle(i % 2 == 1, 0, 8'(i), 8'h00, 0);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 499) == 0) begin
                midReset();
            end else begin
                cycle($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
                      8'($urandom), 8'($urandom), $urandom_range(0, 9) == 0);
            end
        end
        for (int i = 0; i < 6; i++) cycle(0, 0, 8'h00, 8'h00, 1);
        check("final_empty", 32'(empty), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
